// File: rtl/cpe_pkg.sv
// cpe_pkg: shared widths, reset PC default and fetch FSM state type for the cpe core
package cpe_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {ST_START, ST_RUN, ST_HALT} cpe_fetch_state_e;
endpackage

// File: rtl/cpe_fetch_fifo.sv
// cpe_fetch_fifo: synchronous FIFO with flush, occupancy count and full/empty flags
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  empties the FIFO next cycle (wins over push/pop)
//   push_i, wdata_i          write; accepted when not full or when popping
//   pop_i, rdata_o           read; rdata_o is the registered head entry
//   count_o, full_o, empty_o occupancy
module cpe_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic wr, rd;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rp_q];
  assign rd = pop_i & ~empty_o;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign wr = push_i & (~full_o | rd);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) mem_q[wp_q] <= wdata_i;
      wp_q <= wr ? wp_q + AW'(1) : wp_q;
      rp_q <= rd ? rp_q + AW'(1) : rp_q;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/cpe_fetch.sv
// cpe_fetch: RV32I instruction fetch unit with credit-limited request issue and output FIFO
//   clk_w_i, res_w_i_l            clock, asynchronous active-low reset
//   redir_w_i_h, redir_pc_w_i     one-cycle redirect strobe and target
//   imem_req/addr/gnt             request/grant word fetch to instruction memory
//   imem_rvalid/rdata             in-order responses, latency >= 1
//   instr_w_o, instr_pc_w_o       instruction and its PC to the core
//   instr_vld_w_o_h/rdy_w_i_h     valid/ready handshake to the core
//   misalign_w_o_h                misaligned redirect flag, only with CPE_FETCH_MISALIGN_EN
module cpe_fetch
  import cpe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk_w_i,
  input  logic            res_w_i_l,
  input  logic            redir_w_i_h,
  input  logic [XLEN-1:0] redir_pc_w_i,
  output logic            imem_req_w_o_h,
  output logic [XLEN-1:0] imem_addr_w_o,
  input  logic            imem_gnt_w_i_h,
  input  logic            imem_rvalid_w_i_h,
  input  logic [ILEN-1:0] imem_rdata_w_i,
  output logic [ILEN-1:0] instr_w_o,
  output logic [XLEN-1:0] instr_pc_w_o,
  output logic            instr_vld_w_o_h,
  input  logic            instr_rdy_w_i_h
`ifdef CPE_FETCH_MISALIGN_EN
  ,
  output logic            misalign_w_o_h
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  cpe_fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, fifo_cnt;
  logic [XLEN+ILEN-1:0] fifo_rdata;
  logic acc, rv, push, pop, fifo_full, fifo_empty, mis;
`ifdef CPE_FETCH_MISALIGN_EN
  logic mis_q, mis_d;
  assign redir_pc = redir_pc_w_i;
  assign mis = redir_w_i_h & (redir_pc_w_i[1:0] != 2'b00);
  assign mis_d = redir_w_i_h ? mis : mis_q;
  assign misalign_w_o_h = mis_q;
`else
  assign redir_pc = {redir_pc_w_i[XLEN-1:2], redir_pc_w_i[1:0] & 2'b00};
  assign mis = 1'b0;
`endif
  // buffered plus outstanding words never exceed DEPTH, so every response has a slot
  assign imem_req_w_o_h = (state_q == ST_RUN) & ~redir_w_i_h &
                          (({1'b0, fifo_cnt} + {1'b0, out_q}) < CAP);
  assign imem_addr_w_o = pc_q;
  assign acc = imem_req_w_o_h & imem_gnt_w_i_h;
  // a response with nothing outstanding is a protocol error and is ignored
  assign rv = imem_rvalid_w_i_h & (out_q != '0);
  assign pop = instr_vld_w_o_h & instr_rdy_w_i_h;
  assign push = rv & ~redir_w_i_h & (disc_q == '0) & (~fifo_full | pop);
  assign out_d = out_q + CW'(acc) - CW'(rv);
  assign pc_d = redir_w_i_h ? redir_pc : acc ? pc_q + 32'd4 : pc_q;
  // rsp_pc tracks the PC of the next response that will be kept
  assign rsp_pc_d = redir_w_i_h ? redir_pc : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
  // everything in flight at a redirect is stale, including a response landing that cycle
  assign disc_d = redir_w_i_h ? out_q - CW'(rv) :
                  (rv && disc_q != '0) ? disc_q - CW'(1) : disc_q;
  assign instr_vld_w_o_h = ~fifo_empty;
  assign instr_w_o = fifo_rdata[ILEN-1:0];
  assign instr_pc_w_o = fifo_rdata[XLEN+ILEN-1:ILEN];
  always_comb begin
    state_d = state_q;
    state_d = redir_w_i_h ? (mis ? ST_HALT : ST_RUN) :
              (state_q == ST_START) ? ST_RUN : state_q;
  end
  always_ff @(posedge clk_w_i or negedge res_w_i_l)
    if (!res_w_i_l) begin
      state_q <= ST_START;
      pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q <= '0;
      disc_q <= '0;
`ifdef CPE_FETCH_MISALIGN_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
`ifdef CPE_FETCH_MISALIGN_EN
      mis_q <= mis_d;
`endif
    end
  cpe_fetch_fifo #(.DEPTH(DEPTH), .W(XLEN+ILEN)) u_fifo (
    .clk_i   (clk_w_i),
    .rst_ni  (res_w_i_l),
    .flush_i (redir_w_i_h),
    .push_i  (push),
    .wdata_i ({rsp_pc_q, imem_rdata_w_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_cpe_fetch.sv
// tb_cpe_fetch: directed self-checking bench for cpe_fetch with an in-order latency memory model
module tb_cpe_fetch;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic redir, gnt, rdy, spur;
  logic mrv = 1'b0;
  logic [31:0] redir_pc;
  logic [31:0] mrdata = 32'h0;
  logic req, vld, rvalid;
  logic [31:0] addr, instr, ipc;
`ifdef CPE_FETCH_MISALIGN_EN
  logic mis;
`endif
  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cyc = 0;
  logic [31:0] q_addr [$];
  int q_due [$];

  always #5 clk = ~clk;
  assign rvalid = mrv | spur;

  cpe_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_w_i           (clk),
    .res_w_i_l         (rst_l),
    .redir_w_i_h       (redir),
    .redir_pc_w_i      (redir_pc),
    .imem_req_w_o_h    (req),
    .imem_addr_w_o     (addr),
    .imem_gnt_w_i_h    (gnt),
    .imem_rvalid_w_i_h (rvalid),
    .imem_rdata_w_i    (mrdata),
    .instr_w_o         (instr),
    .instr_pc_w_o      (ipc),
    .instr_vld_w_o_h   (vld),
    .instr_rdy_w_i_h   (rdy)
`ifdef CPE_FETCH_MISALIGN_EN
    ,
    .misalign_w_o_h    (mis)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // memory: a request granted in cycle k answers in cycle k+lat, in order
  always @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      q_addr.delete();
      q_due.delete();
      cyc <= 0;
    end else begin
      if (mrv) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (req && gnt) begin
        q_addr.push_back(addr);
        q_due.push_back(cyc + lat);
      end
      cyc <= cyc + 1;
    end

  always @(negedge clk) begin
    mrv <= q_due.size() > 0 && q_due[0] <= cyc;
    mrdata <= (q_due.size() > 0 && q_due[0] <= cyc) ? memf(q_addr[0]) : 32'h0;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic g, input logic r);
    rst_l = 1'b0; redir = 1'b0; redir_pc = 32'h0; spur = 1'b0;
    lat = l; gnt = g; rdy = r;
    tick; tick;
    rst_l = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_l = 1'b0; redir = 1'b0; redir_pc = 32'h0; spur = 1'b0;
    lat = 1; gnt = 1'b1; rdy = 1'b1;
    tick; tick;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", req); end
    checks++; if (addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", addr); end
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b want=0", vld); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", instr); end
    checks++; if (ipc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", ipc); end
`ifdef CPE_FETCH_MISALIGN_EN
    checks++; if (mis !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b want=0", mis); end
`endif
    rst_l = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL start_req got=%b want=0", req); end
    tick;
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h want=1/0", req, addr); end
  endtask

  task automatic test_stream;
    do_reset(1, 1'b1, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      tick;
      checks++;
      if (req !== 1'b1 || addr !== 32'(4*(c-1))) begin
        failures++; $display("FAIL stream_req c=%0d got=%b/%h want=1/%h", c, req, addr, 32'(4*(c-1)));
      end
      checks++;
      if (c >= 3) begin
        if (vld !== 1'b1 || ipc !== 32'(4*(c-3)) || instr !== memf(32'(4*(c-3)))) begin
          failures++; $display("FAIL stream_out c=%0d got=%b/%h/%h want=1/%h/%h", c, vld, ipc, instr, 32'(4*(c-3)), memf(32'(4*(c-3))));
        end
      end else if (vld !== 1'b0) begin
        failures++; $display("FAIL stream_early c=%0d vld got=%b want=0", c, vld);
      end
    end
  endtask

  task automatic test_backpressure;
    int grants;
    grants = 0;
    do_reset(3, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (req === 1'b1 && gnt) grants++;
    end
    checks++; if (grants !== 4) begin failures++; $display("FAIL bp_grants got=%0d want=4", grants); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL bp_req_low got=%b want=0", req); end
    checks++; if (vld !== 1'b1 || ipc !== 32'h0) begin failures++; $display("FAIL bp_head got=%b/%h want=1/0", vld, ipc); end
    rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      checks++;
      if (vld !== 1'b1 || ipc !== 32'(4*k) || instr !== memf(32'(4*k))) begin
        failures++; $display("FAIL bp_drain k=%0d got=%b/%h/%h want=1/%h/%h", k, vld, ipc, instr, 32'(4*k), memf(32'(4*k)));
      end
      if (k == 1) begin
        checks++; if (req !== 1'b1 || addr !== 32'h10) begin failures++; $display("FAIL bp_resume got=%b/%h want=1/10", req, addr); end
      end
    end
  endtask

  task automatic test_redirect;
    do_reset(3, 1'b1, 1'b1);
    tick; tick; tick;
    redir = 1'b1; redir_pc = 32'h100;
    #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL redir_req got=%b want=0", req); end
    tick;
    redir = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h100) begin failures++; $display("FAIL redir_target got=%b/%h want=1/100", req, addr); end
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL redir_vld c=4 got=%b want=0", vld); end
    for (int c = 5; c <= 7; c++) begin
      tick;
      checks++; if (vld !== 1'b0) begin failures++; $display("FAIL redir_stale c=%0d vld got=%b pc=%h want=0", c, vld, ipc); end
    end
    tick;
    checks++; if (vld !== 1'b1 || ipc !== 32'h100 || instr !== memf(32'h100)) begin failures++; $display("FAIL redir_first got=%b/%h/%h want=1/100/%h", vld, ipc, instr, memf(32'h100)); end
    tick;
    checks++; if (vld !== 1'b1 || ipc !== 32'h104) begin failures++; $display("FAIL redir_second got=%b/%h want=1/104", vld, ipc); end
  endtask

  task automatic test_redir_rvalid;
    do_reset(2, 1'b1, 1'b0);
    tick; tick; tick; tick;
    gnt = 1'b0; rdy = 1'b1; redir = 1'b1; redir_pc = 32'h40;
    #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rr_req got=%b want=0", req); end
    checks++; if (vld !== 1'b1 || ipc !== 32'h0 || instr !== memf(32'h0)) begin failures++; $display("FAIL rr_pop got=%b/%h/%h want=1/0/%h", vld, ipc, instr, memf(32'h0)); end
    tick;
    redir = 1'b0;
    #1;
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rr_flush got=%b want=0", vld); end
    checks++; if (req !== 1'b1 || addr !== 32'h40) begin failures++; $display("FAIL rr_target got=%b/%h want=1/40", req, addr); end
    tick;
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rr_discard got=%b pc=%h want=0", vld, ipc); end
    checks++; if (req !== 1'b1 || addr !== 32'h40) begin failures++; $display("FAIL rr_hold got=%b/%h want=1/40", req, addr); end
    gnt = 1'b1;
    tick;
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rr_c7 vld got=%b want=0", vld); end
    tick;
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rr_c8 vld got=%b want=0", vld); end
    tick;
    checks++; if (vld !== 1'b1 || ipc !== 32'h40 || instr !== memf(32'h40)) begin failures++; $display("FAIL rr_first got=%b/%h/%h want=1/40/%h", vld, ipc, instr, memf(32'h40)); end
  endtask

  task automatic test_gnt_stall;
    do_reset(1, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick;
      checks++;
      if (req !== 1'b1 || addr !== 32'h0 || vld !== 1'b0) begin
        failures++; $display("FAIL stall c=%0d got req=%b addr=%h vld=%b want 1/0/0", c, req, addr, vld);
      end
    end
    tick;
    gnt = 1'b1;
    tick;
    checks++; if (vld !== 1'b0 || addr !== 32'h4) begin failures++; $display("FAIL stall_after got vld=%b addr=%h want 0/4", vld, addr); end
    tick;
    checks++; if (vld !== 1'b1 || ipc !== 32'h0 || instr !== memf(32'h0)) begin failures++; $display("FAIL stall_out got=%b/%h/%h want=1/0/%h", vld, ipc, instr, memf(32'h0)); end
  endtask

  task automatic test_spurious;
    do_reset(1, 1'b0, 1'b1);
    tick; tick;
    spur = 1'b1;
    tick;
    spur = 1'b0;
    #1;
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL spur_vld got=%b want=0", vld); end
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin failures++; $display("FAIL spur_req got=%b/%h want=1/0", req, addr); end
    gnt = 1'b1;
    tick; tick;
    checks++; if (vld !== 1'b1 || ipc !== 32'h0 || instr !== memf(32'h0)) begin failures++; $display("FAIL spur_out got=%b/%h/%h want=1/0/%h", vld, ipc, instr, memf(32'h0)); end
  endtask

  task automatic test_mid_reset;
    do_reset(1, 1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) tick;
    rst_l = 1'b0;
    #1;
    checks++; if (vld !== 1'b0 || ipc !== 32'h0 || instr !== 32'h0) begin failures++; $display("FAIL midrst_out got=%b/%h/%h want=0/0/0", vld, ipc, instr); end
    checks++; if (req !== 1'b0 || addr !== 32'h0) begin failures++; $display("FAIL midrst_req got=%b/%h want=0/0", req, addr); end
  endtask

`ifdef CPE_FETCH_MISALIGN_EN
  task automatic test_misalign;
    do_reset(1, 1'b1, 1'b1);
    tick; tick; tick;
    redir = 1'b1; redir_pc = 32'h102;
    tick;
    redir = 1'b0;
    #1;
    checks++; if (mis !== 1'b1 || req !== 1'b0 || vld !== 1'b0) begin failures++; $display("FAIL mis_set got mis=%b req=%b vld=%b want 1/0/0", mis, req, vld); end
    for (int c = 5; c <= 6; c++) begin
      tick;
      checks++; if (mis !== 1'b1 || req !== 1'b0) begin failures++; $display("FAIL mis_halt c=%0d got mis=%b req=%b want 1/0", c, mis, req); end
    end
    redir = 1'b1; redir_pc = 32'h200;
    tick;
    redir = 1'b0;
    #1;
    checks++; if (mis !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin failures++; $display("FAIL mis_clear got mis=%b req=%b addr=%h want 0/1/200", mis, req, addr); end
    tick; tick;
    checks++; if (vld !== 1'b1 || ipc !== 32'h200 || instr !== memf(32'h200)) begin failures++; $display("FAIL mis_resume got=%b/%h/%h want=1/200/%h", vld, ipc, instr, memf(32'h200)); end
  endtask
`else
  task automatic test_align_force;
    do_reset(1, 1'b1, 1'b1);
    tick; tick; tick;
    redir = 1'b1; redir_pc = 32'h102;
    tick;
    redir = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h100) begin failures++; $display("FAIL align_req got=%b/%h want=1/100", req, addr); end
    tick; tick;
    checks++; if (vld !== 1'b1 || ipc !== 32'h100 || instr !== memf(32'h100)) begin failures++; $display("FAIL align_out got=%b/%h/%h want=1/100/%h", vld, ipc, instr, memf(32'h100)); end
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_redir_rvalid;
    test_gnt_stall;
    test_spurious;
`ifdef CPE_FETCH_MISALIGN_EN
    test_misalign;
`else
    test_align_force;
`endif
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
